// File: rtl/mem_responder.sv
// mem_responder: memory-side target for the hmc-6502 CPU bus. Decodes a window,
// inserts wait states via rdy and services reads/writes to an internal byte array.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] WP_LIMIT    = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        rdy,
    output logic [7:0]  rdata,
    output logic        read_drive_en,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] off;
    logic                 is_read;
    logic [7:0]           mem [0:(1 << ADDR_BITS) - 1];

    logic sel;
    logic accept;
    logic new_prot;
    logic off_prot;

    if (WAIT_STATES > 15) begin : g_wait_states_check
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end

    assign sel      = req && (addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
    assign accept   = sel && rdy;
    assign new_prot = 16'(addr[ADDR_BITS-1:0]) < WP_LIMIT;
    assign off_prot = 16'(off) < WP_LIMIT;

    // Outputs are registered: each transition loads the values of the state it enters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            off           <= '0;
            is_read       <= 1'b1;
            rdy           <= 1'b1;
            read_drive_en <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state         <= DATA;
                        cnt           <= '0;
                        rdy           <= 1'b1;
                        read_drive_en <= is_read;
                        err           <= !is_read && off_prot;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    // IDLE and DATA share the accept path, giving back-to-back accesses
                    if (accept) begin
                        off     <= addr[ADDR_BITS-1:0];
                        is_read <= rw;
                        if (WAIT_STATES == 0) begin
                            state         <= DATA;
                            rdy           <= 1'b1;
                            read_drive_en <= rw;
                            err           <= !rw && new_prot;
                        end else begin
                            state         <= WAIT;
                            cnt           <= 4'(WAIT_STATES);
                            rdy           <= 1'b0;
                            read_drive_en <= 1'b0;
                            err           <= 1'b0;
                        end
                    end else begin
                        state         <= IDLE;
                        rdy           <= 1'b1;
                        read_drive_en <= 1'b0;
                        err           <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array has no reset; a write in flight when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (!reset && state == DATA && !is_read && !off_prot) begin
            mem[off] <= wdata;
        end
    end

    assign rdata = read_drive_en ? mem[off] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with WAIT_STATES 2, 0 and 3,
// directed accesses push expected data-phase events, a negedge monitor checks them.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  reset;
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [2:0]  rdy;
    logic [2:0]  rde;
    logic [2:0]  err;
    logic [15:0] addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  rdata [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        int         at;
        bit         rde;
        bit         err;
        logic [7:0] data;
        bit         dc;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] seen_rdata = 8'h00;
    logic [7:0] prior;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .ADDR_BITS  (10),
            .BASE       (16'h0000),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3)),
            .WP_LIMIT   (16'h0100)
        ) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .req          (req[g]),
            .rw           (rw[g]),
            .addr         (addr[g]),
            .wdata        (wdata[g]),
            .rdy          (rdy[g]),
            .rdata        (rdata[g]),
            .read_drive_en(rde[g]),
            .err          (err[g])
        );
    end

    function automatic int ws(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every visible data-phase event must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset[i] === 1'b0) begin
                if (rde[i] === 1'b1 || err[i] === 1'b1) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: inst %0d rde=%0b err=%0b rdata=%0h, none expected",
                                 i, rde[i], err[i], rdata[i]);
                    end else begin : mon_pop
                        exp_t e;
                        e = sbq.pop_front();
                        check("mon_inst", i, e.inst);
                        check("mon_cycle", cyc, e.at);
                        check("mon_rde", {31'd0, rde[i]}, {31'd0, e.rde});
                        check("mon_err", {31'd0, err[i]}, {31'd0, e.err});
                        if (!e.dc) check("mon_rdata", {24'd0, rdata[i]}, {24'd0, e.data});
                        seen_rdata = rdata[i];
                    end
                end else begin
                    check("quiet_rdata", {24'd0, rdata[i]}, 32'd0);
                end
            end
        end
    end

    // Single access, entered and left at #1 after a posedge with the target idle.
    task automatic access(input int i, input bit r, input logic [15:0] a, input logic [7:0] d,
                          input bit perr, input logic [7:0] erd, input bit dc, input bit wiggle);
        int stalls = 0;
        check("rdy_before_access", {31'd0, rdy[i]}, 32'd1);
        req[i]   = 1'b1;
        rw[i]    = r;
        addr[i]  = a;
        wdata[i] = 8'h00;
        @(posedge clk); #1;
        if (r || perr) sbq.push_back('{i, cyc + ws(i), r, perr, r ? erd : 8'h00, dc});
        wdata[i] = d;
        if (!wiggle) req[i] = 1'b0;
        while (rdy[i] !== 1'b1 && stalls < 40) begin
            stalls++;
            if (wiggle) addr[i] = addr[i] + 16'd1;
            @(posedge clk); #1;
        end
        req[i] = 1'b0;
        check("stall_cycles", stalls, ws(i));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = '1;
        req   = '0;
        rw    = '1;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 16'h0000;
            wdata[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_rdy", {31'd0, rdy[i]}, 32'd1);
            check("reset_rde", {31'd0, rde[i]}, 32'd0);
            check("reset_err", {31'd0, err[i]}, 32'd0);
            check("reset_rdata", {24'd0, rdata[i]}, 32'd0);
        end
        reset = '0;
        @(posedge clk); #1;

        // W=2: write then read back
        access(0, 1'b0, 16'h0200, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        access(0, 1'b1, 16'h0200, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);

        // W=2: address wiggled during WAIT must not move the latched offset
        access(0, 1'b0, 16'h0201, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);
        access(0, 1'b0, 16'h0202, 8'h88, 1'b0, 8'h00, 1'b0, 1'b0);
        access(0, 1'b1, 16'h0200, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b1);
        access(0, 1'b1, 16'h0202, 8'h00, 1'b0, 8'h88, 1'b0, 1'b0);

        // Protected write: err in its data cycle, contents unchanged
        access(0, 1'b1, 16'h0010, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        prior = seen_rdata;
        access(0, 1'b0, 16'h0010, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
        access(0, 1'b1, 16'h0010, 8'h00, 1'b0, prior, 1'b0, 1'b0);

        // Out-of-window requests: never accepted
        for (int k = 0; k < 2; k++) begin
            req[0]  = 1'b1;
            rw[0]   = 1'b1;
            addr[0] = (k == 0) ? 16'h8000 : 16'h0400;
            repeat (5) begin
                @(posedge clk); #1;
                check("oow_rdy", {31'd0, rdy[0]}, 32'd1);
                check("oow_rde", {31'd0, rde[0]}, 32'd0);
            end
            req[0] = 1'b0;
        end
        access(0, 1'b1, 16'h0201, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);

        // W=0: back-to-back write 0300=11, read 0300, read 0301
        access(1, 1'b0, 16'h0301, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        req[1]  = 1'b1;
        rw[1]   = 1'b0;
        addr[1] = 16'h0300;
        @(posedge clk); #1;
        check("b2b_rdy_write", {31'd0, rdy[1]}, 32'd1);
        wdata[1] = 8'h11;
        rw[1]    = 1'b1;
        @(posedge clk); #1;
        sbq.push_back('{1, cyc, 1'b1, 1'b0, 8'h11, 1'b0});
        check("b2b_rdy_read0", {31'd0, rdy[1]}, 32'd1);
        addr[1] = 16'h0301;
        @(posedge clk); #1;
        sbq.push_back('{1, cyc, 1'b1, 1'b0, 8'h22, 1'b0});
        check("b2b_rdy_read1", {31'd0, rdy[1]}, 32'd1);
        req[1] = 1'b0;
        @(posedge clk); #1;

        // W=0: protection boundary at WP_LIMIT
        access(1, 1'b0, 16'h00FF, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0);
        access(1, 1'b0, 16'h0100, 8'h6B, 1'b0, 8'h00, 1'b0, 1'b0);
        access(1, 1'b1, 16'h0100, 8'h00, 1'b0, 8'h6B, 1'b0, 1'b0);

        // W=3: reset in the 2nd WAIT cycle of a write drops it
        access(2, 1'b0, 16'h0250, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        req[2]  = 1'b1;
        rw[2]   = 1'b0;
        addr[2] = 16'h0250;
        @(posedge clk); #1;
        wdata[2] = 8'hC3;
        check("wait1_rdy", {31'd0, rdy[2]}, 32'd0);
        @(posedge clk); #1;
        check("wait2_rdy", {31'd0, rdy[2]}, 32'd0);
        reset[2] = 1'b1;
        @(posedge clk); #1;
        reset[2] = 1'b0;
        req[2]   = 1'b0;
        check("midreset_rdy", {31'd0, rdy[2]}, 32'd1);
        check("midreset_rde", {31'd0, rde[2]}, 32'd0);
        check("midreset_err", {31'd0, err[2]}, 32'd0);
        check("midreset_rdata", {24'd0, rdata[2]}, 32'd0);
        @(posedge clk); #1;
        check("postreset_rdy", {31'd0, rdy[2]}, 32'd1);
        access(2, 1'b1, 16'h0250, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
